// File: rtl/agc_pkg.sv
// Shared constants and helpers for the multi-channel AGC loop filter.
// Datapath values are signed fixed point with FRAC fractional bits.
package agc_pkg;

    localparam int W_DEF        = 16;
    localparam int FRAC_DEF     = 8;
    localparam int NCH_DEF      = 4;

    // Unity gain in the default Q format
    localparam int ONE          = 1 << FRAC_DEF;

    // Default clamp limits: non-negative gain up to the largest positive value
    localparam int GAIN_MIN_DEF = 0;
    localparam int GAIN_MAX_DEF = (1 << (W_DEF - 1)) - 1;

    // Width of a channel index; at least one bit even for a single channel
    function automatic int chw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/agc_loop_filter_mc_if.sv
// Sample/result bus of the AGC loop filter.
// master drives error samples and control, slave returns gain results.
interface agc_loop_filter_mc_if
    import agc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int NCH  = NCH_DEF
);
    localparam int CHW = chw(NCH);

    logic                  err_valid;
    logic [CHW-1:0]        err_ch;
    logic signed [W-1:0]   error;
    logic signed [W-1:0]   mu;
    logic signed [W-1:0]   initial_gain;
    logic signed [W-1:0]   gain_min;
    logic signed [W-1:0]   gain_max;
    logic                  freeze;
    logic                  load;

    logic                  gain_valid;
    logic [CHW-1:0]        gain_ch;
    logic signed [W-1:0]   gain;
    logic                  sat_hi;
    logic                  sat_lo;

    modport master (
        output err_valid, err_ch, error, mu, initial_gain,
               gain_min, gain_max, freeze, load,
        input  gain_valid, gain_ch, gain, sat_hi, sat_lo
    );

    modport slave (
        input  err_valid, err_ch, error, mu, initial_gain,
               gain_min, gain_max, freeze, load,
        output gain_valid, gain_ch, gain, sat_hi, sat_lo
    );

endinterface

// File: rtl/agc_sat.sv
// Combinational clamp of a wide signed value into [i_min, i_max].
// The upper limit is applied first, then the lower one, so an inverted
// window (min > max) always resolves to i_min with only sat_lo raised.
module agc_sat
    import agc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = 2 * W_DEF + 2
) (
    input  logic signed [IW-1:0] i_value,
    input  logic signed [W-1:0]  i_min,
    input  logic signed [W-1:0]  i_max,
    output logic signed [W-1:0]  o_value,
    output logic                 o_sat_hi,
    output logic                 o_sat_lo
);

    logic signed [IW-1:0] w_minExt;
    logic signed [IW-1:0] w_maxExt;
    logic signed [IW-1:0] w_hiClamped;
    logic signed [IW-1:0] w_result;

    assign w_minExt = {{(IW - W){i_min[W-1]}}, i_min};
    assign w_maxExt = {{(IW - W){i_max[W-1]}}, i_max};

    // Clamp against the upper limit, then the lower limit; flags follow the final result
    always_comb begin
        o_sat_hi    = 1'b0;
        o_sat_lo    = 1'b0;
        w_hiClamped = i_value;
        if (i_value > w_maxExt) begin
            w_hiClamped = w_maxExt;
            o_sat_hi    = 1'b1;
        end
        w_result = w_hiClamped;
        if (w_hiClamped < w_minExt) begin
            w_result = w_minExt;
            o_sat_lo = 1'b1;
            o_sat_hi = 1'b0;
        end
    end

    assign o_value = w_result[W-1:0];

endmodule

// File: rtl/agc_loop_filter_mc.sv
// Multi-channel AGC loop filter: gain[ch] += round(error*mu >> FRAC), clamped.
// Stage 1 registers the product, stage 2 does a read-modify-write of the
// channel's gain register and drives the result, so a sample on the very
// next cycle already sees the updated gain.
module agc_loop_filter_mc
    import agc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int NCH  = NCH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    agc_loop_filter_mc_if.slave   bus
);

    localparam int CHW = chw(NCH);
    localparam int PW  = 2 * W;
    localparam int SW  = PW + 2;
    localparam logic [PW:0] RND = (PW + 1)'(1) << (FRAC - 1);

    logic                  w_chOk;
    logic                  w_accept;
    logic signed [PW-1:0]  w_prod;

    logic                  r_s1Valid;
    logic [CHW-1:0]        r_s1Ch;
    logic signed [PW-1:0]  r_s1Prod;
    logic                  r_s1Freeze;
    logic                  r_s1Load;

    logic signed [W-1:0]   r_gainMem [NCH];

    logic signed [W-1:0]   w_oldGain;
    logic signed [PW:0]    w_prodRnd;
    logic signed [PW:0]    w_upd;
    logic signed [SW-1:0]  w_sum;
    logic signed [W-1:0]   w_clamped;
    logic                  w_satHi;
    logic                  w_satLo;
    logic signed [W-1:0]   w_newGain;
    logic                  w_newHi;
    logic                  w_newLo;

    logic                  r_gainValid;
    logic [CHW-1:0]        r_gainCh;
    logic signed [W-1:0]   r_gain;
    logic                  r_satHi;
    logic                  r_satLo;

    // Out-of-range channel indices only exist when NCH is not a power of two
    if ((1 << CHW) > NCH) begin : g_chCheck
        assign w_chOk = (bus.err_ch < CHW'(NCH));
    end else begin : g_chAll
        assign w_chOk = 1'b1;
    end

    assign w_accept = bus.err_valid && w_chOk;
    assign w_prod   = bus.error * bus.mu;

    // Stage 1: capture the full-width product and the sample's control bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Ch     <= '0;
            r_s1Prod   <= '0;
            r_s1Freeze <= 1'b0;
            r_s1Load   <= 1'b0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Ch     <= bus.err_ch;
                r_s1Prod   <= w_prod;
                r_s1Freeze <= bus.freeze;
                r_s1Load   <= bus.load;
            end
        end
    end

    assign w_oldGain = r_gainMem[r_s1Ch];
    assign w_prodRnd = {r_s1Prod[PW-1], r_s1Prod} + RND;
    assign w_upd     = w_prodRnd >>> FRAC;
    assign w_sum     = {w_upd[PW], w_upd} + {{(SW - W){w_oldGain[W-1]}}, w_oldGain};

    agc_sat #(
        .W  (W),
        .IW (SW)
    ) u_sat (
        .i_value  (w_sum),
        .i_min    (bus.gain_min),
        .i_max    (bus.gain_max),
        .o_value  (w_clamped),
        .o_sat_hi (w_satHi),
        .o_sat_lo (w_satLo)
    );

    // Select the stage 2 result: load beats freeze, both bypass the clamp
    always_comb begin
        w_newGain = w_clamped;
        w_newHi   = w_satHi;
        w_newLo   = w_satLo;
        if (r_s1Load) begin
            w_newGain = bus.initial_gain;
            w_newHi   = 1'b0;
            w_newLo   = 1'b0;
        end else if (r_s1Freeze) begin
            w_newGain = w_oldGain;
            w_newHi   = 1'b0;
            w_newLo   = 1'b0;
        end
    end

    // Stage 2: write back the channel gain and register the result; outputs hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_gainMem[i] <= bus.initial_gain;
            end
            r_gainValid <= 1'b0;
            r_gainCh    <= '0;
            r_gain      <= '0;
            r_satHi     <= 1'b0;
            r_satLo     <= 1'b0;
        end else begin
            r_gainValid <= r_s1Valid;
            if (r_s1Valid) begin
                if (!r_s1Freeze || r_s1Load) begin
                    r_gainMem[r_s1Ch] <= w_newGain;
                end
                r_gainCh <= r_s1Ch;
                r_gain   <= w_newGain;
                r_satHi  <= w_newHi;
                r_satLo  <= w_newLo;
            end
        end
    end

    assign bus.gain_valid = r_gainValid;
    assign bus.gain_ch    = r_gainCh;
    assign bus.gain       = r_gain;
    assign bus.sat_hi     = r_satHi;
    assign bus.sat_lo     = r_satLo;

endmodule

// File: tb/tb_agc_loop_filter_mc.sv
// Bench for agc_loop_filter_mc: directed scenarios plus random traffic,
// compared every cycle against a serial per-channel gain model.
module tb_agc_loop_filter_mc;
    import agc_pkg::*;

    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int NCH  = 4;

    typedef struct {
        int     due;
        int     ch;
        longint g;
        bit     hi;
        bit     lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    agc_loop_filter_mc_if #(.W(W), .FRAC(FRAC), .NCH(NCH)) bus ();

    agc_loop_filter_mc #(.W(W), .FRAC(FRAC), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t   expQ[$];
    longint mg[NCH];
    int     edgeCnt     = 0;
    int     testsRun    = 0;
    int     testsFailed = 0;
    bit     expValid    = 1'b0;
    int     hCh         = 0;
    longint hG          = 0;
    bit     hHi         = 1'b0;
    bit     hLo         = 1'b0;
    longint lastGain[NCH];
    bit     lastHi      = 1'b0;
    bit     lastLo      = 1'b0;

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        testsRun++;
        if (obs != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Serial reference: each accepted sample updates its channel immediately,
    // and its result is due on the output one clock edge later.
    task automatic modelEdge();
        exp_t   e;
        longint g, prod, upd, r;
        bit     sh, sl;
        int     ch;
        edgeCnt++;
        if (rst) begin
            for (int i = 0; i < NCH; i++) mg[i] = sx(bus.initial_gain);
            expQ.delete();
            expValid = 1'b0;
            hCh = 0; hG = 0; hHi = 1'b0; hLo = 1'b0;
            return;
        end
        expValid = 1'b0;
        if (expQ.size() > 0 && expQ[0].due == edgeCnt) begin
            e = expQ.pop_front();
            expValid = 1'b1;
            hCh = e.ch; hG = e.g; hHi = e.hi; hLo = e.lo;
        end
        if (bus.err_valid) begin
            ch = int'(bus.err_ch);
            g  = mg[ch];
            sh = 1'b0;
            sl = 1'b0;
            if (bus.load) begin
                r = sx(bus.initial_gain);
            end else if (bus.freeze) begin
                r = g;
            end else begin
                prod = sx(bus.error) * sx(bus.mu);
                upd  = (prod + (longint'(1) << (FRAC - 1))) >>> FRAC;
                r    = g + upd;
                if (r > sx(bus.gain_max)) begin r = sx(bus.gain_max); sh = 1'b1; end
                if (r < sx(bus.gain_min)) begin r = sx(bus.gain_min); sl = 1'b1; sh = 1'b0; end
            end
            mg[ch] = r;
            e.due = edgeCnt + 1; e.ch = ch; e.g = r; e.hi = sh; e.lo = sl;
            expQ.push_back(e);
        end
    endtask

    task automatic checkCycle();
        checkOutput("gain_valid", longint'(bus.gain_valid), longint'(expValid));
        checkOutput("gain_ch", longint'(bus.gain_ch), longint'(hCh));
        checkOutput("gain", sx(bus.gain), hG);
        checkOutput("sat_hi", longint'(bus.sat_hi), longint'(hHi));
        checkOutput("sat_lo", longint'(bus.sat_lo), longint'(hLo));
        if (bus.gain_valid) begin
            lastGain[bus.gain_ch] = sx(bus.gain);
            lastHi = bus.sat_hi;
            lastLo = bus.sat_lo;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle();
    endtask

    task automatic applyStimulus(input bit v, input int ch, input logic [W-1:0] e,
                                 input logic [W-1:0] m, input bit f, input bit l);
        bus.err_valid = v;
        bus.err_ch    = 2'(ch);
        bus.error     = e;
        bus.mu        = m;
        bus.freeze    = f;
        bus.load      = l;
        stepCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) lastGain[i] = 0;
        bus.err_valid    = 1'b0;
        bus.err_ch       = '0;
        bus.error        = '0;
        bus.mu           = '0;
        bus.freeze       = 1'b0;
        bus.load         = 1'b0;
        bus.initial_gain = 16'(ONE);
        bus.gain_min     = 16'(GAIN_MIN_DEF);
        bus.gain_max     = 16'(GAIN_MAX_DEF);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single update: 0x100 + round(0x80*0x40 >> 8) = 0x120
        applyStimulus(1'b1, 0, 16'h0080, 16'h0040, 1'b0, 1'b0);
        idle(2);
        checkOutput("first_update", lastGain[0], 64'h0120);

        // Reload ch0, then four back-to-back updates
        applyStimulus(1'b1, 0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 16'h0080, 16'h0040, 1'b0, 1'b0);
        idle(2);
        checkOutput("back_to_back", lastGain[0], 64'h0180);

        // Upper and lower saturation on ch1
        bus.gain_max     = 16'h0200;
        bus.gain_min     = 16'h0040;
        bus.initial_gain = 16'h01F0;
        idle(2);
        applyStimulus(1'b1, 1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        idle(2);
        bus.initial_gain = 16'h0100;
        idle(2);
        applyStimulus(1'b1, 1, 16'h0080, 16'h0040, 1'b0, 1'b0);
        idle(2);
        checkOutput("sat_hi_gain", lastGain[1], 64'h0200);
        checkOutput("sat_hi_flag", longint'(lastHi), 1);
        applyStimulus(1'b1, 1, 16'hFC00, 16'h0100, 1'b0, 1'b0);
        idle(2);
        checkOutput("sat_lo_gain", lastGain[1], 64'h0040);
        checkOutput("sat_lo_flag", longint'(lastLo), 1);

        // ch3 to 0x180, then interleaved freeze (ch2) and load (ch3)
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3, 16'h0080, 16'h0040, 1'b0, 1'b0);
        idle(2);
        checkOutput("ch3_ramp", lastGain[3], 64'h0180);
        applyStimulus(1'b1, 2, 16'h0400, 16'h0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 3, 16'h0400, 16'h0100, 1'b0, 1'b1);
        applyStimulus(1'b1, 2, 16'h0400, 16'h0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 3, 16'h0400, 16'h0100, 1'b1, 1'b1);
        idle(2);
        checkOutput("ch2_frozen", lastGain[2], 64'h0100);
        checkOutput("ch3_loaded", lastGain[3], 64'h0100);
        applyStimulus(1'b1, 0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(2);
        checkOutput("ch0_untouched", lastGain[0], 64'h0180);
        checkOutput("ch1_untouched", lastGain[1], 64'h0040);

        // Rounding at the half-LSB boundary
        applyStimulus(1'b1, 0, 16'h0001, 16'h0080, 1'b0, 1'b0);
        idle(2);
        checkOutput("round_half_up", lastGain[0], 64'h0181);
        applyStimulus(1'b1, 0, 16'h0001, 16'h007F, 1'b0, 1'b0);
        idle(2);
        checkOutput("round_below_half", lastGain[0], 64'h0181);
        applyStimulus(1'b1, 0, 16'hFFFF, 16'h0080, 1'b0, 1'b0);
        idle(2);
        checkOutput("round_neg_half", lastGain[0], 64'h0181);

        // Inverted window resolves to gain_min
        bus.gain_min = 16'h0300;
        bus.gain_max = 16'h0200;
        idle(2);
        applyStimulus(1'b1, 2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle(2);
        checkOutput("inverted_gain", lastGain[2], 64'h0300);
        checkOutput("inverted_lo", longint'(lastLo), 1);
        checkOutput("inverted_hi", longint'(lastHi), 0);

        // Random traffic; limits only change while the pipeline is empty
        bus.gain_min = 16'hF000;
        bus.gain_max = 16'h1000;
        idle(2);
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                idle(2);
                bus.gain_min = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
                bus.gain_max = 16'($urandom_range(0, 16'h0FFF));
                idle(2);
            end
            applyStimulus($urandom_range(0, 9) < 7, int'($urandom_range(0, NCH - 1)),
                          16'($urandom), 16'($urandom_range(0, 16'h03FF)) - 16'h0200,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        idle(2);

        // Reset with samples in flight; a sample on the release cycle is accepted
        applyStimulus(1'b1, 0, 16'h0080, 16'h0040, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1, 16'h0080, 16'h0040, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) applyStimulus(1'b1, c, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(2);
        for (int c = 0; c < NCH; c++) checkOutput("post_reset_gain", lastGain[c], 64'h0100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/agc_loop_filter_mc.md
AGC_LOOP_FILTER_MC -- requirements
Module: agc_loop_filter_mc

Interface
REQ-001 Parameter W, default 16: signed data width of error, mu, gain and limits.
REQ-002 Parameter FRAC, default 8: fractional bits, with every datapath value in Q(W-FRAC).FRAC format.
REQ-003 Parameter NCH, default 4: number of independent gain channels; CHW = max(1, clog2(NCH)).
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset; synchronous, active-high.
REQ-006 err_valid  in  1: error sample present this cycle; always accepted, with no ready signal.
REQ-007 err_ch  in  CHW: channel index of the sample.
REQ-008 error  in  W signed: error sample.
REQ-009 mu  in  W signed: step size, sampled together with error.
REQ-010 initial_gain  in  W signed: reset and reload gain value.
REQ-011 gain_min  in  W signed: lower clamp, quasi-static.
REQ-012 gain_max  in  W signed: upper clamp, quasi-static.
REQ-013 freeze  in  1: with err_valid, hold the channel's gain.
REQ-014 load  in  1: with err_valid, reload the channel's gain to initial_gain.
REQ-015 gain_valid  out  1: result strobe.
REQ-016 gain_ch  out  CHW: channel of the result.
REQ-017 gain  out  W signed: updated gain of gain_ch.
REQ-018 sat_hi  out  1: result was clamped to gain_max.
REQ-019 sat_lo  out  1: result was clamped to gain_min.

Function
REQ-020 Stage 1, on an accepted sample: register prod = error*mu (2W signed), err_ch, freeze and load.
REQ-021 Stage 1 scaling: upd = (prod + 2^(FRAC-1)) >>> FRAC, an arithmetic shift with round-half-up, kept at 2W-FRAC+1 bits (no truncation before the clamp).
REQ-022 Stage 2 read-modify-write: sum = gain_mem[ch] + upd at full width; clamp to gain_max first, then to gain_min; write the result to gain_mem[ch] and drive it on gain.
REQ-023 If gain_min > gain_max, the clamp result is gain_min and sat_lo=1.
REQ-024 Latency: gain_valid asserts exactly 2 cycles after err_valid; throughput is one sample per cycle; there is no stall.
REQ-025 Back-to-back samples on the same channel: each one sees the previous write; results are identical to serial processing, with no lost update.
REQ-026 Freeze: gain_mem unchanged; gain_valid still pulses with the held value; sat_hi=sat_lo=0.
REQ-027 Load: gain_mem[ch] = initial_gain; error ignored; load has priority over freeze; sat flags are 0.
REQ-028 err_ch >= NCH: sample dropped; no write; gain_valid stays 0.
REQ-029 gain_ch, gain, sat_hi and sat_lo hold their last value while gain_valid=0.
REQ-030 Channels are fully independent: a write to one channel never alters another.

Reset
REQ-031 While rst=1: every gain_mem entry = initial_gain; gain_valid=0; gain_ch=0; gain=0; sat_hi=sat_lo=0; pipeline valids cleared.
REQ-032 Reset asserted mid-operation discards in-flight stage 1 and 2 samples; no write or strobe follows them.
REQ-033 A sample presented on the cycle rst deasserts is accepted normally.

Structure
REQ-034 Shared package agc_pkg holds default W, FRAC and NCH, the Q-format constant ONE = 2^FRAC, and the default limits GAIN_MIN_DEF = 0 and GAIN_MAX_DEF = 2^(W-1)-1.
REQ-035 Sub-module agc_sat is a combinational, parametrised clamp (wide input, min, max -> W-bit output, sat_hi, sat_lo); it is instantiated once in stage 2.
REQ-036 gain_mem is a register array of NCH x W, not an inferred RAM, to allow same-cycle reset of all entries.

Verification
REQ-037 W=16, FRAC=8, NCH=4; initial 0x0100; ch0 error=0x0080, mu=0x0040 -> 2 cycles later gain_valid=1, ch=0, gain=0x0120.
REQ-038 Four consecutive cycles on ch0 with the same error/mu -> gains 0x0120, 0x0140, 0x0160, 0x0180 on consecutive cycles.
REQ-039 gain_max=0x0200, ch1 preloaded to 0x01F0, update 0x0020 -> gain=0x0200, sat_hi=1; negative error driving the gain below gain_min=0x0040 -> gain=0x0040, sat_lo=1.
REQ-040 Interleave ch2 (freeze=1) and ch3 (load=1, initial 0x0100 after ch3 has reached 0x0180) -> ch2 gain unchanged; ch3 gain=0x0100; ch0 and ch1 unaffected.
REQ-041 Rounding: error=0x0001, mu=0x0080 (prod 0x80) -> upd=1; error=0x0001, mu=0x007F -> upd=0; error=0xFFFF, mu=0x0080 -> upd=0.
REQ-042 Assert rst for 1 cycle with 2 samples in flight -> no gain_valid follows; all channels read initial_gain on the next sample.
